// File: rtl/instr_mem_server.sv
// Instruction-memory responder: one outstanding fetch over valid/ready, fixed-latency
// read with same-edge load forwarding, and an always-open host load port.
module instr_mem_server #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic load_in_range;
  logic addr_in_range;

  // Compare in full address width plus one bit so no high address can alias into range.
  assign load_in_range = ({1'b0, load_addr} < DEPTH_A);
  assign addr_in_range = ({1'b0, addr_q} < DEPTH_A);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (load_valid && load_in_range) mem_d[load_addr[IDX_W-1:0]] = load_data;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = LAT_M1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          if (addr_in_range) begin
            rsp_err_d = 1'b0;
            // A load hitting the same word on the sampling edge wins over the stored copy.
            if (load_valid && (load_addr == addr_q)) rsp_data_d = load_data;
            else                                     rsp_data_d = mem_q[addr_q[IDX_W-1:0]];
          end else begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d    = IDLE;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_instr_mem_server.sv
// Directed bench for instr_mem_server: image load/fetch, stalls, range errors,
// load forwarding and mid-operation reset.
module tb_instr_mem_server;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  logic [15:0] img [16] = '{16'hA5A5, 16'h5A5A, 16'h1234, 16'hDEAD, 16'h8765, 16'hABCD,
                            16'h1122, 16'hAABB, 16'hDEAD, 16'hF00D, 16'hC0FF, 16'h0000,
                            16'hCAFE, 16'h1234, 16'h4321, 16'h9999};

  instr_mem_server #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(16), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    load_valid = 1'b1; load_addr = a; load_data = d;
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  // hold: cycles to keep rsp_ready low in RESP; ld_at: edge offset from accept for a
  // same-address load (0 = none); keepreq: leave req_valid high through BUSY/RESP.
  task automatic fetch(input logic [15:0] a, input logic [15:0] exp_d, input logic exp_e,
                       input int hold, input int ld_at, input logic [15:0] ld_d,
                       input bit keepreq, input string tag);
    int lat;
    @(negedge clk);
    check({tag, ".req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_addr = a; rsp_ready = (hold == 0);
    @(posedge clk);
    #1 if (!keepreq) req_valid = 1'b0;
    lat = 0;
    while (1) begin
      lat++;
      if (lat == ld_at) begin
        load_valid = 1'b1; load_addr = a; load_data = ld_d;
      end
      @(posedge clk);
      #1 load_valid = 1'b0;
      @(negedge clk);
      if (rsp_valid || lat > 20) break;
    end
    check({tag, ".latency"}, lat, LAT);
    check({tag, ".data"}, rsp_data, exp_d);
    check({tag, ".err"}, rsp_err, exp_e);
    if (ld_at == lat + 1) begin
      load_valid = 1'b1; load_addr = a; load_data = ld_d;
    end
    for (int h = 0; h < hold; h++) begin
      if (keepreq) req_addr = 16'h0000;
      @(posedge clk);
      #1 load_valid = 1'b0;
      @(negedge clk);
      check({tag, ".hold_valid"}, rsp_valid, 1);
      check({tag, ".hold_data"}, rsp_data, exp_d);
      check({tag, ".hold_ready"}, req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 load_valid = 1'b0;
    @(negedge clk);
    check({tag, ".done_valid"}, rsp_valid, 0);
    check({tag, ".done_data"}, rsp_data, 0);
    check({tag, ".done_ready"}, req_ready, 1);
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst.req_ready", req_ready, 1);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_data", rsp_data, 0);
    check("rst.rsp_err", rsp_err, 0);

    for (int i = 0; i < 16; i++) do_load(16'(i), img[i]);
    for (int i = 0; i < 16; i++) fetch(16'(i), img[i], 1'b0, 0, 0, 16'h0, 1'b0, "img");

    fetch(16'd3, 16'hDEAD, 1'b0, 5, 0, 16'h0, 1'b1, "stall3");

    fetch(16'd16, 16'h0000, 1'b1, 0, 0, 16'h0, 1'b0, "err16");
    fetch(16'hFFFF, 16'h0000, 1'b1, 0, 0, 16'h0, 1'b0, "errFFFF");

    fetch(16'd5, 16'hBEEF, 1'b0, 0, LAT, 16'hBEEF, 1'b0, "fwd_same");
    do_load(16'd5, 16'hABCD);
    fetch(16'd5, 16'hABCD, 1'b0, 0, LAT + 1, 16'hBEEF, 1'b0, "fwd_late");
    fetch(16'd5, 16'hBEEF, 1'b0, 0, 0, 16'h0, 1'b0, "fwd_after");
    do_load(16'd5, 16'hABCD);

    do_load(16'd20, 16'h1111);
    for (int i = 0; i < 16; i++) fetch(16'(i), img[i], 1'b0, 0, 0, 16'h0, 1'b0, "img2");

    // Reset while BUSY, with a competing load that reset must override.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 16'd3; rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1; load_valid = 1'b1; load_addr = 16'd0; load_data = 16'h7777;
    @(posedge clk);
    #1 reset = 1'b0; load_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rstbusy.no_rsp", rsp_valid, 0);
    end
    check("rstbusy.req_ready", req_ready, 1);
    fetch(16'd0, 16'h0000, 1'b0, 0, 0, 16'h0, 1'b0, "rst_addr0");
    fetch(16'd15, 16'h0000, 1'b0, 0, 0, 16'h0, 1'b0, "rst_addr15");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
